// File: rtl/sprite_draw_scheduler.sv
// Per-frame sprite draw sequencer.
// On frame_tick it walks the sprite table in index order. For each valid
// entry it runs a draw_start/draw_done handshake with the drawer, with a
// per-sprite timeout. After the last entry it holds a buffer swap request
// until it is acknowledged, then pulses frame_done.
//
// state | meaning
// IDLE  | waiting for frame_tick
// FETCH | table read strobe for the current index
// CHECK | table_valid returned for the current index
// START | one-cycle draw_start to the drawer
// WAIT  | waiting for draw_done or timeout
// SWAP  | swap_req held until swap_ack
module sprite_draw_scheduler #(
  parameter int NUM_SPRITES    = 8,
  parameter int IDX_WIDTH      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int OVR_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 frame_tick,
  output logic                 table_rd_en,
  output logic [IDX_WIDTH-1:0] table_rd_idx,
  input  logic                 table_valid,
  output logic                 draw_start,
  output logic [IDX_WIDTH-1:0] draw_idx,
  input  logic                 draw_done,
  output logic                 swap_req,
  input  logic                 swap_ack,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 timeout_err,
  input  logic                 err_clr,
  output logic [OVR_WIDTH-1:0] overrun_cnt
);

  // Timeout is a down-counter: loaded with TIMEOUT_CYCLES-1 in START and
  // terminal at zero, so WAIT lasts at most TIMEOUT_CYCLES cycles.
  localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_SPRITES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CHECK = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_SWAP  = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   frame_done_q;
  logic                   tmo_err_q;
  logic [OVR_WIDTH-1:0]   ovr_q;
  logic                   tmo_set;
  logic                   ovr_inc;
  logic                   last_idx;

  assign last_idx = (idx_q == LAST_IDX);
  assign ovr_inc  = frame_tick && (state_q != S_IDLE);

  // Next-state, index and timeout counter decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tmo_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end
      end
      S_FETCH: state_d = S_CHECK;
      S_CHECK: begin
        if (table_valid) begin
          state_d = S_START;
        end else if (last_idx) begin
          state_d = S_SWAP;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_START: begin
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (draw_done || (cnt_q == '0)) begin
          // a draw_done on the terminal cycle still counts as a completed draw
          tmo_set = !draw_done;
          if (last_idx) begin
            state_d = S_SWAP;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SWAP: begin
        if (swap_ack) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State, index, counter and frame_done registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      frame_done_q <= (state_q == S_SWAP) && swap_ack;
    end
  end

  // Sticky timeout flag and saturating overrun counter; a set/increment
  // in the same cycle as err_clr takes priority over the clear.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tmo_err_q <= 1'b0;
      ovr_q     <= '0;
    end else begin
      if (tmo_set) begin
        tmo_err_q <= 1'b1;
      end else if (err_clr) begin
        tmo_err_q <= 1'b0;
      end
      if (ovr_inc) begin
        if (err_clr) begin
          ovr_q <= OVR_WIDTH'(1);
        end else if (ovr_q != {OVR_WIDTH{1'b1}}) begin
          ovr_q <= ovr_q + 1'b1;
        end
      end else if (err_clr) begin
        ovr_q <= '0;
      end
    end
  end

  assign table_rd_en  = (state_q == S_FETCH);
  assign draw_start   = (state_q == S_START);
  assign swap_req     = (state_q == S_SWAP);
  assign busy         = (state_q != S_IDLE);
  assign table_rd_idx = idx_q;
  assign draw_idx     = idx_q;
  assign frame_done   = frame_done_q;
  assign timeout_err  = tmo_err_q;
  assign overrun_cnt  = ovr_q;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Bench for sprite_draw_scheduler. Each frame's expected event schedule
// (read cycles, draw_start cycles, swap/frame_done cycles, timeout cycle,
// overrun count) is computed from the frame rules with plain arithmetic and
// compared against the events observed from the DUT.
module tb_sprite_draw_scheduler;
  localparam int NS  = 8;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rstn;
  logic       frame_tick;
  logic       table_rd_en;
  logic [2:0] table_rd_idx;
  logic       table_valid;
  logic       draw_start;
  logic [2:0] draw_idx;
  logic       draw_done;
  logic       swap_req;
  logic       swap_ack;
  logic       frame_done;
  logic       busy;
  logic       timeout_err;
  logic       err_clr;
  logic [7:0] overrun_cnt;

  int n_checks = 0;
  int n_fails  = 0;
  int ovr_exp  = 0;
  int lat_cfg [NS];

  sprite_draw_scheduler #(
    .NUM_SPRITES(NS), .TIMEOUT_CYCLES(TMO), .OVR_WIDTH(8)
  ) dut (
    .clk(clk), .rstn(rstn), .frame_tick(frame_tick),
    .table_rd_en(table_rd_en), .table_rd_idx(table_rd_idx),
    .table_valid(table_valid), .draw_start(draw_start), .draw_idx(draw_idx),
    .draw_done(draw_done), .swap_req(swap_req), .swap_ack(swap_ack),
    .frame_done(frame_done), .busy(busy), .timeout_err(timeout_err),
    .err_clr(err_clr), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic clr);
    frame_tick = 1'b0;
    err_clr    = clr;
    if (clr) ovr_exp = 0;
    for (int i = 0; i < n; i++) begin
      table_valid = 1'($urandom_range(0, 1));
      draw_done   = 1'($urandom_range(0, 1));
      swap_ack    = 1'($urandom_range(0, 1));
      step();
      err_clr = 1'b0;
    end
    table_valid = 1'b0;
    draw_done   = 1'b0;
    swap_ack    = 1'b0;
  endtask

  // Runs one frame. Entry: at posedge+1 with the DUT idle; that cycle is
  // cycle 0 and carries the frame_tick. Exit: in the frame_done cycle.
  task automatic run_frame(input logic [7:0] mask, input int ack_delay,
                           input int extra_tick, input int clr_at,
                           input string tag, output logic had_to);
    int exp_rd_c[$], exp_rd_i[$], exp_st_c[$], exp_st_i[$];
    int obs_rd_c[$], obs_rd_i[$], obs_st_c[$], obs_st_i[$];
    int t, s, w, swap_c, ack_c, fd_c, to_c, c;
    int sw_first, sw_cnt, fd_obs, to_obs, start_c, start_lat, idx_bad, busy_bad;
    logic any_to, pending, prev_rd, busy_fd, done;
    logic [2:0] prev_idx, start_i;

    // expected schedule
    t = 1; any_to = 1'b0; to_c = -1;
    for (int i = 0; i < NS; i++) begin
      exp_rd_c.push_back(t);
      exp_rd_i.push_back(i);
      if (mask[i]) begin
        s = t + 2;
        exp_st_c.push_back(s);
        exp_st_i.push_back(i);
        if (lat_cfg[i] >= 1 && lat_cfg[i] <= TMO) begin
          w = lat_cfg[i];
        end else begin
          w = TMO;
          if (!any_to) to_c = s + 1 + TMO;
          any_to = 1'b1;
        end
        t = s + 1 + w;
      end else begin
        t = t + 2;
      end
    end
    swap_c = t;
    ack_c  = t + ack_delay;
    fd_c   = ack_c + 1;
    if (clr_at > 0) ovr_exp = 0;
    if (extra_tick >= 1 && extra_tick <= ack_c && ovr_exp < 255) ovr_exp++;
    had_to = any_to;

    // drive and observe
    c = 0; sw_first = -1; sw_cnt = 0; fd_obs = -1; to_obs = -1;
    start_c = -1; start_lat = 0; start_i = '0; idx_bad = 0; busy_bad = 0;
    pending = 1'b0; prev_rd = 1'b0; prev_idx = '0; busy_fd = 1'b1; done = 1'b0;
    frame_tick = 1'b1;
    draw_done  = 1'b0;
    swap_ack   = 1'b0;
    err_clr    = (clr_at == 0);
    err_clr    = 1'b0;
    table_valid = 1'($urandom_range(0, 1));
    while (!done && c < 3000) begin
      step();
      c++;
      if (table_rd_en) begin
        obs_rd_c.push_back(c);
        obs_rd_i.push_back(int'(table_rd_idx));
      end
      if (table_rd_en || swap_req) pending = 1'b0;
      if (draw_start) begin
        obs_st_c.push_back(c);
        obs_st_i.push_back(int'(draw_idx));
        start_c   = c;
        start_i   = draw_idx;
        start_lat = lat_cfg[draw_idx];
        pending   = 1'b1;
      end
      if (pending && draw_idx !== start_i) idx_bad++;
      if (swap_req) begin
        if (sw_first < 0) sw_first = c;
        sw_cnt++;
      end
      if (timeout_err === 1'b1 && to_obs < 0) to_obs = c;
      if (c < fd_c && busy !== 1'b1) busy_bad++;
      if (frame_done === 1'b1) begin
        fd_obs  = c;
        busy_fd = busy;
        done    = 1'b1;
      end
      frame_tick  = (c == extra_tick);
      err_clr     = (c == clr_at);
      table_valid = prev_rd ? mask[prev_idx] : 1'($urandom_range(0, 1));
      prev_rd     = table_rd_en;
      prev_idx    = table_rd_idx;
      if (start_c >= 0 && start_lat > 0 && c == start_c + start_lat) begin
        draw_done = 1'b1;
        pending   = 1'b0;
      end else begin
        draw_done = table_rd_en && ($urandom_range(0, 2) == 0);
      end
      if (sw_first >= 0 && c == sw_first + ack_delay)
        swap_ack = 1'b1;
      else
        swap_ack = (draw_start || table_rd_en) && ($urandom_range(0, 2) == 0);
    end
    frame_tick = 1'b0;
    draw_done  = 1'b0;
    swap_ack   = 1'b0;
    err_clr    = 1'b0;

    n_checks++;
    if (!done) begin
      n_fails++;
      $display("FAIL %s frame_done_wait: no frame_done within %0d cycles, required cycle %0d", tag, c, fd_c);
    end
    n_checks++;
    if (obs_rd_c.size() !== exp_rd_c.size()) begin
      n_fails++;
      $display("FAIL %s rd_count: got %0d reads, expected %0d", tag, obs_rd_c.size(), exp_rd_c.size());
    end
    for (int i = 0; i < obs_rd_c.size() && i < exp_rd_c.size(); i++) begin
      n_checks++;
      if (obs_rd_c[i] !== exp_rd_c[i] || obs_rd_i[i] !== exp_rd_i[i]) begin
        n_fails++;
        $display("FAIL %s rd[%0d]: got cycle %0d idx %0d, expected cycle %0d idx %0d",
                 tag, i, obs_rd_c[i], obs_rd_i[i], exp_rd_c[i], exp_rd_i[i]);
      end
    end
    n_checks++;
    if (obs_st_c.size() !== exp_st_c.size()) begin
      n_fails++;
      $display("FAIL %s start_count: got %0d draw_start, expected %0d", tag, obs_st_c.size(), exp_st_c.size());
    end
    for (int i = 0; i < obs_st_c.size() && i < exp_st_c.size(); i++) begin
      n_checks++;
      if (obs_st_c[i] !== exp_st_c[i] || obs_st_i[i] !== exp_st_i[i]) begin
        n_fails++;
        $display("FAIL %s start[%0d]: got cycle %0d idx %0d, expected cycle %0d idx %0d",
                 tag, i, obs_st_c[i], obs_st_i[i], exp_st_c[i], exp_st_i[i]);
      end
    end
    n_checks++;
    if (sw_first !== swap_c || sw_cnt !== ack_c - swap_c + 1) begin
      n_fails++;
      $display("FAIL %s swap_req: got rise %0d for %0d cycles, expected rise %0d for %0d cycles",
               tag, sw_first, sw_cnt, swap_c, ack_c - swap_c + 1);
    end
    n_checks++;
    if (fd_obs !== fd_c || busy_fd !== 1'b0) begin
      n_fails++;
      $display("FAIL %s frame_done: got cycle %0d busy %0b, expected cycle %0d busy 0", tag, fd_obs, busy_fd, fd_c);
    end
    n_checks++;
    if (busy_bad !== 0) begin
      n_fails++;
      $display("FAIL %s busy_during_frame: %0d cycles low, expected 0", tag, busy_bad);
    end
    n_checks++;
    if (idx_bad !== 0) begin
      n_fails++;
      $display("FAIL %s draw_idx_stable: %0d cycles changed, expected 0", tag, idx_bad);
    end
    n_checks++;
    if (to_obs !== to_c || timeout_err !== any_to) begin
      n_fails++;
      $display("FAIL %s timeout_err: got rise %0d final %0b, expected rise %0d final %0b",
               tag, to_obs, timeout_err, to_c, any_to);
    end
    n_checks++;
    if (overrun_cnt !== 8'(ovr_exp)) begin
      n_fails++;
      $display("FAIL %s overrun_cnt: got %0d, expected %0d", tag, overrun_cnt, ovr_exp);
    end
  endtask

  task automatic set_lat(input int v);
    for (int i = 0; i < NS; i++) lat_cfg[i] = v;
  endtask

  task automatic test_reset();
    rstn = 1'b0; frame_tick = 1'b0; table_valid = 1'b0; draw_done = 1'b0;
    swap_ack = 1'b0; err_clr = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({table_rd_en, table_rd_idx, draw_start, draw_idx, swap_req, frame_done,
         busy, timeout_err, overrun_cnt} !== 23'd0) begin
      n_fails++;
      $display("FAIL reset_outputs: got rd_en=%0b rd_idx=%0d start=%0b draw_idx=%0d swap=%0b done=%0b busy=%0b err=%0b ovr=%0d, expected all 0",
               table_rd_en, table_rd_idx, draw_start, draw_idx, swap_req, frame_done, busy, timeout_err, overrun_cnt);
    end
    rstn = 1'b1;
    ovr_exp = 0;
    step();
  endtask

  task automatic test_all_valid();
    logic to;
    set_lat(1);
    run_frame(8'hFF, 2, 0, 0, "all_valid", to);
    idle(2, 1'b0);
  endtask

  task automatic test_sparse();
    logic to;
    set_lat(1);
    run_frame(8'h24, 1, 0, 0, "sparse", to);
    idle(1, 1'b0);
  endtask

  task automatic test_none_valid();
    logic to;
    run_frame(8'h00, 0, 0, 0, "none_valid", to);
    idle(1, 1'b0);
  endtask

  task automatic test_timeout();
    logic to;
    set_lat(0);
    // err_clr on the last WAIT cycle must lose to the timeout set
    run_frame(8'h01, 1, 0, 19, "timeout", to);
    idle(1, 1'b1);
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fails++;
      $display("FAIL timeout_clear: got timeout_err=%0b, expected 0", timeout_err);
    end
    set_lat(1);
    lat_cfg[0] = TMO;
    lat_cfg[7] = TMO - 1;
    run_frame(8'h81, 3, 0, 0, "timeout_edge", to);
    idle(1, 1'b0);
  endtask

  task automatic test_overrun();
    logic to;
    set_lat(1);
    run_frame(8'hFF, 2, 10, 0, "overrun_one", to);
    idle(1, 1'b0);
    frame_tick = 1'b1; table_valid = 1'b0; swap_ack = 1'b0; draw_done = 1'b0;
    repeat (320) step();
    n_checks++;
    if (overrun_cnt !== 8'd255 || swap_req !== 1'b1) begin
      n_fails++;
      $display("FAIL overrun_saturate: got ovr=%0d swap_req=%0b, expected 255 and 1", overrun_cnt, swap_req);
    end
    err_clr = 1'b1;
    step();
    n_checks++;
    if (overrun_cnt !== 8'd1) begin
      n_fails++;
      $display("FAIL overrun_clr_vs_inc: got %0d, expected 1", overrun_cnt);
    end
    err_clr = 1'b0; frame_tick = 1'b0; swap_ack = 1'b1;
    step();
    swap_ack = 1'b0;
    n_checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL overrun_frame_end: got frame_done=%0b busy=%0b, expected 1 and 0", frame_done, busy);
    end
    idle(1, 1'b1);
    n_checks++;
    if (overrun_cnt !== 8'd0) begin
      n_fails++;
      $display("FAIL overrun_clear: got %0d, expected 0", overrun_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic to;
    set_lat(2);
    run_frame(8'h5A, 1, 0, 0, "b2b_first", to);
    // frame_tick in the frame_done cycle starts the next frame
    run_frame(8'hA5, 0, 0, 0, "b2b_second", to);
    idle(2, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    logic to, prev_rd;
    logic [2:0] prev_idx;
    prev_rd = 1'b0; prev_idx = '0;
    frame_tick = 1'b1; table_valid = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      step();
      frame_tick  = 1'b0;
      table_valid = prev_rd && (prev_idx == 3'd3);
      prev_rd     = table_rd_en;
      prev_idx    = table_rd_idx;
    end
    n_checks++;
    if (busy !== 1'b1 || draw_idx !== 3'd3 || draw_start !== 1'b0 || table_rd_en !== 1'b0) begin
      n_fails++;
      $display("FAIL pre_reset_wait: got busy=%0b draw_idx=%0d start=%0b rd_en=%0b, expected 1 3 0 0",
               busy, draw_idx, draw_start, table_rd_en);
    end
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    n_checks++;
    if ({table_rd_en, table_rd_idx, draw_start, draw_idx, swap_req, frame_done,
         busy, timeout_err, overrun_cnt} !== 23'd0) begin
      n_fails++;
      $display("FAIL reset_mid_wait: got rd_en=%0b rd_idx=%0d start=%0b draw_idx=%0d swap=%0b done=%0b busy=%0b err=%0b ovr=%0d, expected all 0",
               table_rd_en, table_rd_idx, draw_start, draw_idx, swap_req, frame_done, busy, timeout_err, overrun_cnt);
    end
    ovr_exp = 0;
    draw_done = 1'b1;
    step();
    draw_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if (swap_req !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
        n_fails++;
        $display("FAIL post_reset_idle[%0d]: got swap=%0b busy=%0b done=%0b, expected 0 0 0",
                 c, swap_req, busy, frame_done);
      end
      step();
    end
    set_lat(1);
    run_frame(8'h09, 1, 0, 0, "after_reset", to);
    idle(1, 1'b0);
  endtask

  task automatic test_random();
    logic to;
    logic [7:0] mask;
    int ack, ex;
    for (int f = 0; f < 12; f++) begin
      mask = 8'($urandom);
      for (int i = 0; i < NS; i++)
        lat_cfg[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TMO));
      ack = int'($urandom_range(0, 4));
      ex  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 17)) : 0;
      run_frame(mask, ack, ex, 0, "random", to);
      if (to || $urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)), 1'b1);
    end
    idle(1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_all_valid();
    test_sparse();
    test_none_valid();
    test_timeout();
    test_overrun();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
